// File: rtl/button_conditioner.sv
// button_conditioner: per-channel synchronizer, debouncer, press/release
// edge pulses and optional auto-repeat for a bank of push buttons.
module button_conditioner #(
  parameter int               N_BTN           = 4,
  parameter int               DEBOUNCE_CYCLES = 250000,
  parameter int               REPEAT_DELAY    = 6250000,
  parameter int               REPEAT_PERIOD   = 2500000,
  parameter logic [N_BTN-1:0] REPEAT_MASK     = 4'b0111
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  // Debounce counter only ever holds 0..DEBOUNCE_CYCLES-1.
  localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

  logic [N_BTN-1:0] sync_p0;
  logic [N_BTN-1:0] sync_p1;
  logic [DB_W-1:0]  db_cnt [N_BTN];
  logic [N_BTN-1:0] differ;
  logic [N_BTN-1:0] toggle;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] fall;

  rpt_state_t       state_q [N_BTN];
  rpt_state_t       state_d [N_BTN];
  logic [RPT_W-1:0] rpt_cnt [N_BTN];
  logic [N_BTN-1:0] rpt_clr;
  logic [N_BTN-1:0] rpt_pulse;

  // Stage p0/p1: two-flop synchronizer for the asynchronous button inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
    end
  end

  assign differ = sync_p1 ^ btn_level;
  assign rise   = toggle & ~btn_level;
  assign fall   = toggle & btn_level;

  // A channel flips once its new level has persisted for the full count.
  always_comb begin
    toggle = '0;
    for (int i = 0; i < N_BTN; i++) begin
      toggle[i] = differ[i] && (db_cnt[i] == DB_LAST);
    end
  end

  // Debounce counters and accepted level; any match restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_level <= '0;
      for (int i = 0; i < N_BTN; i++) db_cnt[i] <= '0;
    end else begin
      btn_level <= btn_level ^ toggle;
      for (int i = 0; i < N_BTN; i++) begin
        if (!differ[i] || toggle[i]) db_cnt[i] <= '0;
        else                         db_cnt[i] <= db_cnt[i] + DB_W'(1);
      end
    end
  end

  // Repeat FSM next state; a falling level overrides everything silently.
  always_comb begin
    rpt_clr   = '0;
    rpt_pulse = '0;
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i] = state_q[i];
      if (fall[i]) begin
        state_d[i] = IDLE;
        rpt_clr[i] = 1'b1;
      end else begin
        case (state_q[i])
          IDLE: begin
            if (rise[i] && REPEAT_MASK[i]) begin
              state_d[i] = DELAY;
              rpt_clr[i] = 1'b1;
            end
          end
          DELAY: begin
            if (rpt_cnt[i] == DELAY_LAST) begin
              state_d[i]   = REPEAT;
              rpt_pulse[i] = 1'b1;
              rpt_clr[i]   = 1'b1;
            end
          end
          REPEAT: begin
            if (rpt_cnt[i] == PERIOD_LAST) begin
              rpt_pulse[i] = 1'b1;
              rpt_clr[i]   = 1'b1;
            end
          end
          default: begin
            state_d[i] = IDLE;
            rpt_clr[i] = 1'b1;
          end
        endcase
      end
    end
  end

  // Repeat FSM state and timing counters; counter parks at 0 while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= IDLE;
        rpt_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= state_d[i];
        if (rpt_clr[i] || (state_q[i] == IDLE)) rpt_cnt[i] <= '0;
        else                                    rpt_cnt[i] <= rpt_cnt[i] + RPT_W'(1);
      end
    end
  end

  // Stage p2: registered pulses, aligned with the level change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_press   <= '0;
      btn_release <= '0;
    end else begin
      btn_press   <= rise | rpt_pulse;
      btn_release <= fall;
    end
  end

endmodule
